// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: multi-transaction vending controller with a persistent credit register,
// per-slot price/exact-fund/sugar rules, saturating stock counters with restock, cancel/refund
// and a registered one-cycle dispense/change handshake.
module vend_ctrl_param #(
    parameter int unsigned NUM_PRODUCTS = 5,
    parameter int unsigned PID_W        = 3,
    parameter int unsigned MONEY_W      = 6,
    parameter int unsigned STOCK_W      = 5,
    parameter int unsigned INIT_STOCK   = 10,
    parameter logic [NUM_PRODUCTS*MONEY_W-1:0] PRICES = {6'd8, 6'd12, 6'd5, 6'd10, 6'd20},
    parameter logic [NUM_PRODUCTS-1:0] EXACT_MASK = 5'b00011,
    parameter logic [NUM_PRODUCTS-1:0] SUGAR_MASK = 5'b11000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin,
    input  logic               select_valid,
    input  logic [PID_W-1:0]   productID,
    input  logic               sugar,
    input  logic               cancel,
    input  logic               restock_valid,
    input  logic [PID_W-1:0]   restock_id,
    input  logic [STOCK_W-1:0] restock_count,
    output logic [MONEY_W-1:0] credit,
    output logic [MONEY_W-1:0] moneyLeft,
    output logic               change_valid,
    output logic [STOCK_W-1:0] itemLeft,
    output logic               productReady,
    output logic               productUnavailable,
    output logic               insufficientFund,
    output logic               notExactFund,
    output logic               invalidProduct,
    output logic               sugarUnsuitable,
    output logic               coinRejected,
    output logic               busy
);

    typedef enum logic [1:0] {StIdle, StCredit, StDispense} state_e;

    state_e             state;
    logic [STOCK_W-1:0] stock   [NUM_PRODUCTS];
    logic [STOCK_W-1:0] stock_n [NUM_PRODUCTS];
    logic [STOCK_W:0]   rsum    [NUM_PRODUCTS];

    logic               sel_id_ok;
    logic [MONEY_W-1:0] sel_price;
    logic [STOCK_W-1:0] sel_stock;
    logic               sel_exact;
    logic               sel_sugar_ok;
    logic [MONEY_W:0]   coin_sum;

    logic active;
    logic select_seen;
    logic e_inv, e_unav, e_sug, e_nex, e_ins;
    logic do_purchase;
    logic coin_reject;

    // Decode the selected slot's attributes; an unmatched ID leaves sel_id_ok low.
    always_comb begin
        sel_id_ok    = 1'b0;
        sel_price    = '0;
        sel_stock    = '0;
        sel_exact    = 1'b0;
        sel_sugar_ok = 1'b0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (productID == PID_W'(i)) begin
                sel_id_ok    = 1'b1;
                sel_price    = PRICES[i*MONEY_W +: MONEY_W];
                sel_stock    = stock[i];
                sel_exact    = EXACT_MASK[i];
                sel_sugar_ok = SUGAR_MASK[i];
            end
        end
    end

    // Select checks in strict priority, all against the credit held before this edge.
    always_comb begin
        coin_sum    = {1'b0, credit} + {1'b0, coin};
        active      = (state != StDispense);
        select_seen = active && select_valid && !cancel;
        e_inv       = !sel_id_ok;
        e_unav      = !e_inv && (sel_stock == '0);
        e_sug       = !e_inv && !e_unav && sugar && !sel_sugar_ok;
        e_nex       = !e_inv && !e_unav && !e_sug && sel_exact && (credit != sel_price);
        e_ins       = !e_inv && !e_unav && !e_sug && !sel_exact && (credit < sel_price);
        do_purchase = select_seen && !(e_inv || e_unav || e_sug || e_nex || e_ins);
        // A coin only lands when nothing of higher priority is happening this cycle.
        coin_reject = coin_valid && (!active || cancel || select_valid || coin_sum[MONEY_W]);
    end

    // Next stock per slot: purchase decrement first, then saturating restock on top.
    always_comb begin
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            stock_n[i] = stock[i];
            rsum[i]    = '0;
            if (do_purchase && (productID == PID_W'(i))) begin
                stock_n[i] = stock[i] - STOCK_W'(1);
            end
            if (restock_valid && (restock_id == PID_W'(i))) begin
                rsum[i]    = {1'b0, stock_n[i]} + {1'b0, restock_count};
                stock_n[i] = rsum[i][STOCK_W] ? '1 : rsum[i][STOCK_W-1:0];
            end
        end
    end

    // Controller state, stock and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= StIdle;
            credit             <= '0;
            moneyLeft          <= '0;
            change_valid       <= 1'b0;
            itemLeft           <= '0;
            productReady       <= 1'b0;
            productUnavailable <= 1'b0;
            insufficientFund   <= 1'b0;
            notExactFund       <= 1'b0;
            invalidProduct     <= 1'b0;
            sugarUnsuitable    <= 1'b0;
            coinRejected       <= 1'b0;
            busy               <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                stock[i] <= stock_n[i];
            end
            change_valid       <= 1'b0;
            productReady       <= 1'b0;
            busy               <= 1'b0;
            invalidProduct     <= select_seen && e_inv;
            productUnavailable <= select_seen && e_unav;
            sugarUnsuitable    <= select_seen && e_sug;
            notExactFund       <= select_seen && e_nex;
            insufficientFund   <= select_seen && e_ins;
            coinRejected       <= coin_reject;

            if (state == StDispense) begin
                state <= StIdle;
            end else if (cancel) begin
                if (state == StCredit) begin
                    moneyLeft    <= credit;
                    change_valid <= 1'b1;
                    credit       <= '0;
                    state        <= StIdle;
                end
            end else if (select_valid) begin
                if (do_purchase) begin
                    moneyLeft    <= credit - sel_price;
                    change_valid <= 1'b1;
                    itemLeft     <= sel_stock - STOCK_W'(1);
                    productReady <= 1'b1;
                    busy         <= 1'b1;
                    credit       <= '0;
                    state        <= StDispense;
                end
            end else if (coin_valid && !coin_sum[MONEY_W] && (coin != '0)) begin
                credit <= coin_sum[MONEY_W-1:0];
                state  <= StCredit;
            end
        end
    end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: a vector table plus hand-written depletion and
// reset-mid-dispense sequences. Outputs are sampled 1 time unit after each rising edge.
module tb_vend_ctrl_param;

    localparam logic [5:0] E_NONE = 6'b000000;
    localparam logic [5:0] E_UNAV = 6'b100000;
    localparam logic [5:0] E_INS  = 6'b010000;
    localparam logic [5:0] E_NEX  = 6'b001000;
    localparam logic [5:0] E_INV  = 6'b000100;
    localparam logic [5:0] E_SUG  = 6'b000010;
    localparam logic [5:0] E_COIN = 6'b000001;

    typedef struct {
        string      name;
        logic       rst;
        logic       cv;
        logic [5:0] coin;
        logic       sv;
        logic [2:0] pid;
        logic       sug;
        logic       can;
        logic       rv;
        logic [2:0] rid;
        logic [4:0] rcnt;
        logic [5:0] e_credit;
        logic [5:0] e_ml;
        logic       e_cv;
        logic [4:0] e_il;
        logic       e_pr;
        logic       e_busy;
        logic [5:0] e_err;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       coin_valid = 1'b0;
    logic [5:0] coin = '0;
    logic       select_valid = 1'b0;
    logic [2:0] productID = '0;
    logic       sugar = 1'b0;
    logic       cancel = 1'b0;
    logic       restock_valid = 1'b0;
    logic [2:0] restock_id = '0;
    logic [4:0] restock_count = '0;
    logic [5:0] credit, moneyLeft;
    logic       change_valid, productReady, busy;
    logic [4:0] itemLeft;
    logic       productUnavailable, insufficientFund, notExactFund;
    logic       invalidProduct, sugarUnsuitable, coinRejected;

    int n_tests = 0;
    int n_fail  = 0;

    vend_ctrl_param dut (
        .CLK                (CLK),
        .RST                (RST),
        .coin_valid         (coin_valid),
        .coin               (coin),
        .select_valid       (select_valid),
        .productID          (productID),
        .sugar              (sugar),
        .cancel             (cancel),
        .restock_valid      (restock_valid),
        .restock_id         (restock_id),
        .restock_count      (restock_count),
        .credit             (credit),
        .moneyLeft          (moneyLeft),
        .change_valid       (change_valid),
        .itemLeft           (itemLeft),
        .productReady       (productReady),
        .productUnavailable (productUnavailable),
        .insufficientFund   (insufficientFund),
        .notExactFund       (notExactFund),
        .invalidProduct     (invalidProduct),
        .sugarUnsuitable    (sugarUnsuitable),
        .coinRejected       (coinRejected),
        .busy               (busy)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(string name, logic rst, logic cv, logic [5:0] cn, logic sv,
                                logic [2:0] pid, logic sug, logic can, logic rv,
                                logic [2:0] rid, logic [4:0] rcnt, logic [5:0] cr,
                                logic [5:0] ml, logic cvo, logic [4:0] il, logic pr,
                                logic bz, logic [5:0] err);
        vec_t v;
        v.name = name; v.rst = rst; v.cv = cv; v.coin = cn; v.sv = sv; v.pid = pid;
        v.sug = sug; v.can = can; v.rv = rv; v.rid = rid; v.rcnt = rcnt;
        v.e_credit = cr; v.e_ml = ml; v.e_cv = cvo; v.e_il = il; v.e_pr = pr;
        v.e_busy = bz; v.e_err = err;
        return v;
    endfunction

    // Drive one cycle of inputs, clock once, then compare every output against the vector.
    task automatic step(input vec_t v);
        logic [5:0] err;
        RST           = v.rst;
        coin_valid    = v.cv;
        coin          = v.coin;
        select_valid  = v.sv;
        productID     = v.pid;
        sugar         = v.sug;
        cancel        = v.can;
        restock_valid = v.rv;
        restock_id    = v.rid;
        restock_count = v.rcnt;
        @(posedge CLK);
        #1;
        err = {productUnavailable, insufficientFund, notExactFund,
               invalidProduct, sugarUnsuitable, coinRejected};
        n_tests++;
        if (credit !== v.e_credit || moneyLeft !== v.e_ml || change_valid !== v.e_cv ||
            itemLeft !== v.e_il || productReady !== v.e_pr || busy !== v.e_busy ||
            err !== v.e_err) begin
            n_fail++;
            $display("FAIL %s: got credit=%0d ml=%0d cv=%0b il=%0d pr=%0b busy=%0b err=%b; want credit=%0d ml=%0d cv=%0b il=%0d pr=%0b busy=%0b err=%b",
                     v.name, credit, moneyLeft, change_valid, itemLeft, productReady, busy,
                     err, v.e_credit, v.e_ml, v.e_cv, v.e_il, v.e_pr, v.e_busy, v.e_err);
        end
    endtask

    // Plain helpers for the hand-written sequences (no restock, no reset).
    task automatic do_coin(input string nm, input logic [5:0] c, input logic [5:0] cr,
                           input logic [5:0] ml, input logic [4:0] il, input logic [5:0] err);
        step(mk(nm, 0, 1, c, 0, 0, 0, 0, 0, 0, 0, cr, ml, 0, il, 0, 0, err));
    endtask

    task automatic do_idle(input string nm, input logic [5:0] cr, input logic [5:0] ml,
                           input logic [4:0] il);
        step(mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cr, ml, 0, il, 0, 0, E_NONE));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[$];
        // name rst cv coin sv pid sug can rv rid rcnt | credit ml cv il pr busy err
        tbl.push_back(mk("reset",         1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,  0, 0, 0, E_NONE));
        tbl.push_back(mk("coin10a",       0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 10,  0, 0,  0, 0, 0, E_NONE));
        tbl.push_back(mk("coin10b",       0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 20,  0, 0,  0, 0, 0, E_NONE));
        tbl.push_back(mk("buy_id0_exact", 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 1,  9, 1, 1, E_NONE));
        tbl.push_back(mk("after_disp",    0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("coin5a",        0, 1,  5, 0, 0, 0, 0, 0, 0, 0,  5,  0, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("coin5b",        0, 1,  5, 0, 0, 0, 0, 0, 0, 0, 10,  0, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("coin5c",        0, 1,  5, 0, 0, 0, 0, 0, 0, 0, 15,  0, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("buy_id3_chg3",  0, 0,  0, 1, 3, 0, 0, 0, 0, 0,  0,  3, 1,  9, 1, 1, E_NONE));
        tbl.push_back(mk("coin_in_disp",  0, 1,  8, 0, 0, 0, 0, 0, 0, 0,  0,  3, 0,  9, 0, 0, E_COIN));
        tbl.push_back(mk("coin8",         0, 1,  8, 0, 0, 0, 0, 0, 0, 0,  8,  3, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("id0_notexact",  0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  8,  3, 0,  9, 0, 0, E_NEX));
        tbl.push_back(mk("cancel8",       0, 0,  0, 0, 0, 0, 1, 0, 0, 0,  0,  8, 1,  9, 0, 0, E_NONE));
        tbl.push_back(mk("coin4",         0, 1,  4, 0, 0, 0, 0, 0, 0, 0,  4,  8, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("id2_sugar",     0, 0,  0, 1, 2, 1, 0, 0, 0, 0,  4,  8, 0,  9, 0, 0, E_SUG));
        tbl.push_back(mk("id6_invalid",   0, 0,  0, 1, 6, 1, 0, 0, 0, 0,  4,  8, 0,  9, 0, 0, E_INV));
        tbl.push_back(mk("id4_insuff",    0, 0,  0, 1, 4, 0, 0, 0, 0, 0,  4,  8, 0,  9, 0, 0, E_INS));
        tbl.push_back(mk("id1_notexact",  0, 0,  0, 1, 1, 0, 0, 0, 0, 0,  4,  8, 0,  9, 0, 0, E_NEX));
        tbl.push_back(mk("cancel4",       0, 0,  0, 0, 0, 0, 1, 0, 0, 0,  0,  4, 1,  9, 0, 0, E_NONE));
        tbl.push_back(mk("cancel_idle",   0, 0,  0, 0, 0, 0, 1, 0, 0, 0,  0,  4, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("id2_zero_cred", 0, 0,  0, 1, 2, 0, 0, 0, 0, 0,  0,  4, 0,  9, 0, 0, E_INS));
        tbl.push_back(mk("coin30a",       0, 1, 30, 0, 0, 0, 0, 0, 0, 0, 30,  4, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("coin30b",       0, 1, 30, 0, 0, 0, 0, 0, 0, 0, 60,  4, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("coin_overflow", 0, 1,  5, 0, 0, 0, 0, 0, 0, 0, 60,  4, 0,  9, 0, 0, E_COIN));
        tbl.push_back(mk("coin_to_63",    0, 1,  3, 0, 0, 0, 0, 0, 0, 0, 63,  4, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("coin_zero",     0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 63,  4, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("sel_plus_coin", 0, 1,  5, 1, 4, 1, 0, 0, 0, 0,  0, 55, 1,  9, 1, 1, E_COIN));
        tbl.push_back(mk("coin_disp2",    0, 1,  7, 0, 0, 0, 0, 0, 0, 0,  0, 55, 0,  9, 0, 0, E_COIN));
        tbl.push_back(mk("coin10c",       0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 10, 55, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("cancel_wins",   0, 1,  1, 1, 2, 0, 1, 0, 0, 0,  0, 10, 1,  9, 0, 0, E_COIN));
        tbl.push_back(mk("restock_id2",   0, 0,  0, 0, 0, 0, 0, 1, 2, 3,  0, 10, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("coin5d",        0, 1,  5, 0, 0, 0, 0, 0, 0, 0,  5, 10, 0,  9, 0, 0, E_NONE));
        tbl.push_back(mk("buy_id2_13",    0, 0,  0, 1, 2, 0, 0, 0, 0, 0,  0,  0, 1, 12, 1, 1, E_NONE));
        tbl.push_back(mk("idle_a",        0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 12, 0, 0, E_NONE));
        tbl.push_back(mk("coin5e",        0, 1,  5, 0, 0, 0, 0, 0, 0, 0,  5,  0, 0, 12, 0, 0, E_NONE));
        tbl.push_back(mk("buy_and_rstk",  0, 0,  0, 1, 2, 0, 0, 1, 2, 2,  0,  0, 1, 11, 1, 1, E_NONE));
        tbl.push_back(mk("idle_b",        0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 0, 11, 0, 0, E_NONE));
        tbl.push_back(mk("coin5f",        0, 1,  5, 0, 0, 0, 0, 0, 0, 0,  5,  0, 0, 11, 0, 0, E_NONE));
        tbl.push_back(mk("buy_id2_merge", 0, 0,  0, 1, 2, 0, 0, 0, 0, 0,  0,  0, 1, 12, 1, 1, E_NONE));
        tbl.push_back(mk("rstk_bad_id",   0, 0,  0, 0, 0, 0, 0, 1, 7, 5,  0,  0, 0, 12, 0, 0, E_NONE));

        foreach (tbl[i]) step(tbl[i]);

        // Deplete slot 1 (price 10, exact) from 10 down to 0.
        for (int k = 0; k < 10; k++) begin
            do_coin("deplete_coin", 10, 10, 0, (k == 0) ? 5'd12 : 5'(10 - k), E_NONE);
            step(mk("deplete_buy", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5'(9 - k), 1, 1,
                    E_NONE));
            do_idle("deplete_idle", 0, 0, 5'(9 - k));
        end
        do_coin("empty_coin", 10, 10, 0, 0, E_NONE);
        step(mk("empty_select", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, E_UNAV));
        step(mk("restock31_a",  0, 0, 0, 0, 0, 0, 0, 1, 1, 31, 10, 0, 0, 0, 0, 0, E_NONE));
        step(mk("restock31_sat", 0, 0, 0, 0, 0, 0, 0, 1, 1, 31, 10, 0, 0, 0, 0, 0, E_NONE));
        step(mk("buy_after_sat", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 30, 1, 1, E_NONE));
        do_idle("sat_idle", 0, 0, 30);

        // Reset in the DISPENSE cycle kills the pulses and restores every stock.
        do_coin("rst_coin20", 20, 20, 0, 30, E_NONE);
        step(mk("rst_buy_id0",  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 1, 1, E_NONE));
        step(mk("rst_in_disp",  1, 1, 5, 1, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, E_NONE));
        do_coin("post_rst_c20", 20, 20, 0, 0, E_NONE);
        step(mk("post_rst_id0", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 1, E_NONE));
        do_idle("post_rst_idle", 0, 0, 9);
        do_coin("post_rst_c10", 10, 10, 0, 9, E_NONE);
        step(mk("post_rst_id1", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 1, E_NONE));
        do_idle("final_idle", 0, 0, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised, multi-transaction vending controller with a persistent credit register, per-product price/exact-fund/sugar rules, per-product stock counters with restock, cancel/refund, and a registered dispense/change handshake. It generalises the single-cycle, two-machine vending block into one configurable engine. It sits between the coin/keypad front end and the dispenser/change mechanism.

## Interface
- `NUM_PRODUCTS`, 5, number of product slots; valid IDs are 0..NUM_PRODUCTS-1.
- `PID_W`, 3, productID width; must satisfy 2^PID_W > NUM_PRODUCTS.
- `MONEY_W`, 6, width of coin, credit and change values.
- `STOCK_W`, 5, stock counter width.
- `INIT_STOCK`, 10, reset stock of every slot.
- `PRICES`, {8,12,5,10,20}, flattened NUM_PRODUCTS*MONEY_W bits; slot i is at bits [i*MONEY_W +: MONEY_W]. Default prices: id0=20, id1=10, id2=5, id3=12, id4=8.
- `EXACT_MASK`, 5'b00011, bit i=1 means slot i requires credit == price exactly.
- `SUGAR_MASK`, 5'b11000, bit i=1 means slot i accepts sugar=1.

Ports:
- `CLK` in 1: single clock; all state changes on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `coin_valid` in 1, `coin` in MONEY_W: coin insertion strobe and value.
- `select_valid` in 1, `productID` in PID_W, `sugar` in 1: purchase request.
- `cancel` in 1: refund request.
- `restock_valid` in 1, `restock_id` in PID_W, `restock_count` in STOCK_W: stock top-up.
- `credit` out MONEY_W: current credit, registered.
- `moneyLeft` out MONEY_W, `change_valid` out 1: change amount, qualified by the strobe.
- `itemLeft` out STOCK_W: stock of the dispensed slot after the decrement.
- `productReady` out 1: dispense pulse.
- `productUnavailable`, `insufficientFund`, `notExactFund`, `invalidProduct`, `sugarUnsuitable`, `coinRejected` out 1 each: one-cycle error pulses.
- `busy` out 1: high in DISPENSE.

## Operation
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0.
  - DISPENSE: one cycle.
- Transitions:
  - IDLE/CREDIT → CREDIT on an accepted coin.
  - CREDIT → IDLE on cancel.
  - IDLE/CREDIT → DISPENSE on a successful select.
  - DISPENSE → IDLE unconditionally.
- Coin acceptance: in IDLE/CREDIT with coin_valid, credit <= credit + coin, computed at MONEY_W+1 bits.
  - If the sum exceeds 2^MONEY_W-1, the coin is rejected: coinRejected pulses and credit is unchanged.
  - coin == 0 is accepted as a no-op with no state change.
- Select checks are evaluated against the credit value before any same-cycle coin. They are applied in strict priority, and only the first failing check fires:
  1. invalidProduct: productID ≥ NUM_PRODUCTS.
  2. productUnavailable: stock == 0.
  3. sugarUnsuitable: sugar=1 and SUGAR_MASK bit is 0.
  4. notExactFund if the EXACT_MASK bit is 1 and credit != price; otherwise insufficientFund if credit < price.
- On any select error, credit is retained and the state is unchanged.
- Successful select: stock[id] decrements, credit clears, and the state goes to DISPENSE. The outputs produced are in Timing.
- Cancel in CREDIT: change_valid=1, moneyLeft=credit, credit=0, state goes to IDLE. Cancel in IDLE does nothing.
- Same-cycle priority is cancel > select > coin.
  - A coin presented in the same cycle as cancel or select is not added and coinRejected pulses.
- In DISPENSE, coin_valid, select_valid and cancel are ignored. A coin in DISPENSE pulses coinRejected.
- Restock is accepted in every state. stock[restock_id] <= min(stock + restock_count, 2^STOCK_W-1).
  - An invalid restock_id is ignored.
  - If the slot is also being decremented by a purchase in the same edge, the result is min(stock - 1 + count, max).
- Stock never wraps below 0, because a select with stock 0 is an error.

## Timing
- All outputs are registered.
- Error pulses and coinRejected are high for exactly one cycle, in the cycle after the sampling edge.
- Purchase latency: select sampled at edge k. During the cycle after edge k (state DISPENSE):
  - productReady=1, change_valid=1, moneyLeft=credit_before-price, itemLeft=new stock, busy=1, credit=0.
- At edge k+1 all of these pulses drop, the state returns to IDLE, and new input is accepted.
- Cancel: change_valid and moneyLeft are valid for one cycle after the sampling edge.
- Between pulses:
  - moneyLeft holds its last value and change_valid=0.
  - itemLeft holds its last value.
- Reset (RST=1 at an edge):
  - State IDLE, credit=0, every stock=INIT_STOCK.
  - moneyLeft=0, itemLeft=0, change_valid=0, busy=0, all pulses 0.
  - Reset overrides every input in the same cycle.
- Reset during DISPENSE cancels the pulses: productReady and change_valid are 0 in the next cycle. The stock decrement already applied is overwritten by INIT_STOCK.

## Test plan
- Exact purchase: after reset, coin 10 then coin 10 → credit=20; select id0 → next cycle productReady=1, moneyLeft=0, itemLeft=9, credit=0.
- Change and accumulation: coins 5, 5, 5 → credit=15; select id3 (12) → moneyLeft=3, change_valid=1. Then credit 8 and select id0 → notExactFund=1 and credit stays 8.
- Error priority: credit 4, select id2 with sugar=1 → sugarUnsuitable only. Select id6 → invalidProduct. Select id4 → insufficientFund, credit=4 retained. Cancel → moneyLeft=4, credit=0.
- Depletion and restock: buy id1 ten times → itemLeft 9..0. The 11th select → productUnavailable. Restock id1 count 31 → stock saturates at 31; the next buy gives itemLeft=30.
- Overflow and collisions: credit 60, coin 5 → coinRejected, credit=60. Select id0 with a coin in the same cycle → coin rejected; coin during DISPENSE → rejected.
- Reset mid-dispense: assert RST in the DISPENSE cycle → productReady low next cycle, credit=0, all stocks 10.
